// File: rtl/controle_arrolhamento.sv
// Corking-station controller: keeps a local cork buffer, refills it in
// batches from the upstream dispenser, seals one bottle per arrival and
// reports stock, sealed count and a cork-shortage alarm.
module controle_arrolhamento #(
  parameter int CAPACIDADE     = 32,
  parameter int LIMIAR         = 4,
  parameter int TEMPO_ARROLHAR = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        GARRAFA_PRESENTE,
  input  logic [7:0]  DISPENSADO,
  input  logic        VAZIO_DISP,
  output logic        PEDIDO,
  output logic        ATUADOR,
  output logic        GARRAFA_OK,
  output logic        FALTA_ROLHA,
  output logic [7:0]  ESTOQUE_LOCAL,
  output logic [15:0] SELADAS
);

  // Timer holds values 0..TEMPO_ARROLHAR-1.
  localparam int TW = (TEMPO_ARROLHAR > 1) ? $clog2(TEMPO_ARROLHAR) : 1;
  localparam logic [TW-1:0] T_INI  = TW'(TEMPO_ARROLHAR - 1);
  localparam logic [TW-1:0] T_UM   = TW'(1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [8:0]    CAP9   = 9'(CAPACIDADE);
  localparam logic [7:0]    LIM8   = 8'(LIMIAR);

  typedef enum logic [2:0] {
    REPOUSO    = 3'd0,
    PEDINDO    = 3'd1,
    ARROLHANDO = 3'd2,
    CONCLUIDO  = 3'd3,
    FALTA      = 3'd4
  } estado_t;

  estado_t        estado_r, estado_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic [7:0]     estoque_r, estoque_s;
  logic [15:0]    seladas_r, seladas_s;
  logic           ok_r, ok_s;
  logic [8:0]     soma_s;
  logic [7:0]     recarga_s;

  // Refill arithmetic: 9-bit sum so the saturation compare never overflows.
  always_comb begin
    soma_s = {1'b0, estoque_r} + {1'b0, DISPENSADO};
    if (soma_s > CAP9) begin
      recarga_s = CAP9[7:0];
    end else begin
      recarga_s = soma_s[7:0];
    end
  end

  // Next-state and datapath update; refill has priority over sealing in REPOUSO.
  always_comb begin
    estado_s  = estado_r;
    timer_s   = timer_r;
    estoque_s = estoque_r;
    seladas_s = seladas_r;
    ok_s      = 1'b0;
    case (estado_r)
      REPOUSO: begin
        if ((estoque_r <= LIM8) && !VAZIO_DISP) begin
          estado_s = PEDINDO;
        end else if (GARRAFA_PRESENTE && (estoque_r != 8'd0)) begin
          estado_s = ARROLHANDO;
          timer_s  = T_INI;
        end else if ((estoque_r == 8'd0) && VAZIO_DISP) begin
          estado_s = FALTA;
        end else begin
          estado_s = REPOUSO;
        end
      end
      PEDINDO: begin
        estoque_s = recarga_s;
        estado_s  = REPOUSO;
      end
      ARROLHANDO: begin
        if (timer_r == T_ZERO) begin
          // Guard keeps the buffer from wrapping even on a corrupted state.
          if (estoque_r != 8'd0) begin
            estoque_s = estoque_r - 8'd1;
          end else begin
            estoque_s = estoque_r;
          end
          seladas_s = seladas_r + 16'd1;
          ok_s      = 1'b1;
          estado_s  = CONCLUIDO;
        end else begin
          timer_s = timer_r - T_UM;
        end
      end
      CONCLUIDO: begin
        // Wait for the bottle to leave so it is never sealed twice.
        if (!GARRAFA_PRESENTE) begin
          estado_s = REPOUSO;
        end else begin
          estado_s = CONCLUIDO;
        end
      end
      FALTA: begin
        if (!VAZIO_DISP) begin
          estado_s = REPOUSO;
        end else begin
          estado_s = FALTA;
        end
      end
      default: begin
        estado_s = REPOUSO;
        timer_s  = T_ZERO;
      end
    endcase
  end

  // State and datapath registers; reset aborts any seal in progress.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado_r  <= REPOUSO;
      timer_r   <= T_ZERO;
      estoque_r <= 8'd0;
      seladas_r <= 16'd0;
      ok_r      <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      timer_r   <= timer_s;
      estoque_r <= estoque_s;
      seladas_r <= seladas_s;
      ok_r      <= ok_s;
    end
  end

  assign PEDIDO        = (estado_r == PEDINDO);
  assign ATUADOR       = (estado_r == ARROLHANDO);
  assign FALTA_ROLHA   = (estado_r == FALTA);
  assign GARRAFA_OK    = ok_r;
  assign ESTOQUE_LOCAL = estoque_r;
  assign SELADAS       = seladas_r;

endmodule

// File: tb/tb_controle_arrolhamento.sv
// Scoreboard bench for controle_arrolhamento: stimulus pushes expected
// refill/seal events, monitors pop and compare when the DUT shows them.
module tb_controle_arrolhamento;

  logic        clock;
  // Instance A: default parameters.
  logic        reset, garrafa, vazio;
  logic [7:0]  disp;
  logic        pedido, atuador, garrafa_ok, falta;
  logic [7:0]  estoque;
  logic [15:0] seladas;
  // Instance B: small capacity to reach saturation.
  logic        rst_b, garrafa_b, vazio_b;
  logic [7:0]  disp_b;
  logic        pedido_b, atuador_b, garrafa_ok_b, falta_b;
  logic [7:0]  estoque_b;
  logic [15:0] seladas_b;

  controle_arrolhamento dut_a (
    .CLOCK(clock), .RESET(reset), .GARRAFA_PRESENTE(garrafa),
    .DISPENSADO(disp), .VAZIO_DISP(vazio), .PEDIDO(pedido),
    .ATUADOR(atuador), .GARRAFA_OK(garrafa_ok), .FALTA_ROLHA(falta),
    .ESTOQUE_LOCAL(estoque), .SELADAS(seladas)
  );

  controle_arrolhamento #(.CAPACIDADE(16), .LIMIAR(4), .TEMPO_ARROLHAR(3)) dut_b (
    .CLOCK(clock), .RESET(rst_b), .GARRAFA_PRESENTE(garrafa_b),
    .DISPENSADO(disp_b), .VAZIO_DISP(vazio_b), .PEDIDO(pedido_b),
    .ATUADOR(atuador_b), .GARRAFA_OK(garrafa_ok_b), .FALTA_ROLHA(falta_b),
    .ESTOQUE_LOCAL(estoque_b), .SELADAS(seladas_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { bit is_seal; int est; int sel; } ev_t;
  ev_t qa[$];
  ev_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_a(input bit s, input int e, input int l);
    ev_t x;
    x.is_seal = s; x.est = e; x.sel = l;
    qa.push_back(x);
  endtask

  task automatic push_b(input int e);
    ev_t x;
    x.is_seal = 1'b0; x.est = e; x.sel = 0;
    qb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one bottle on instance A until it is sealed, then remove it.
  task automatic run_bottle();
    int n;
    garrafa = 1'b1;
    n = 0;
    while (garrafa_ok !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("seal_timeout", (n < 40) ? 1 : 0, 1);
    garrafa = 1'b0;
    tick(); tick(); tick();
  endtask

  // Monitor A: refill result one cycle after PEDIDO, seal result on GARRAFA_OK.
  bit prev_ped_a = 1'b0;
  int run_a = 0;
  always @(negedge clock) begin : mon_a
    ev_t e;
    if (prev_ped_a) begin
      if (qa.size() == 0) begin
        check("unexpected_refill_a", 1, 0);
      end else begin
        e = qa.pop_front();
        check("refill_kind_a", 0, int'(e.is_seal));
        check("refill_est_a", int'(estoque), e.est);
      end
    end
    if (garrafa_ok === 1'b1) begin
      if (qa.size() == 0) begin
        check("unexpected_seal_a", 1, 0);
      end else begin
        e = qa.pop_front();
        check("seal_kind_a", 1, int'(e.is_seal));
        check("seal_est_a", int'(estoque), e.est);
        check("seal_sel_a", int'(seladas), e.sel);
        check("seal_act_cycles_a", run_a, 3);
      end
      run_a = 0;
    end
    if (atuador === 1'b1) run_a++;
    prev_ped_a = (pedido === 1'b1);
    if (reset) begin
      run_a = 0;
      prev_ped_a = 1'b0;
    end
  end

  // Monitor B: only refills are expected on this instance.
  bit prev_ped_b = 1'b0;
  always @(negedge clock) begin : mon_b
    ev_t e;
    if (prev_ped_b) begin
      if (qb.size() == 0) begin
        check("unexpected_refill_b", 1, 0);
      end else begin
        e = qb.pop_front();
        check("refill_est_b", int'(estoque_b), e.est);
      end
    end
    if (garrafa_ok_b === 1'b1) check("unexpected_seal_b", 1, 0);
    prev_ped_b = (pedido_b === 1'b1);
    if (rst_b) prev_ped_b = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; garrafa = 1'b0; vazio = 1'b0; disp = 8'd15;
    rst_b = 1'b1; garrafa_b = 1'b0; vazio_b = 1'b0; disp_b = 8'd4;
    tick(); tick();
    check("rst_estoque", int'(estoque), 0);
    check("rst_seladas", int'(seladas), 0);
    check("rst_pedido", int'(pedido), 0);
    check("rst_atuador", int'(atuador), 0);
    check("rst_ok", int'(garrafa_ok), 0);
    check("rst_falta", int'(falta), 0);

    // Initial refill: PEDIDO in the 2nd cycle after release.
    push_a(1'b0, 15, 0);
    reset = 1'b0;
    tick();
    check("pedido_2nd_cycle", int'(pedido), 1);
    tick();
    check("pedido_one_cycle", int'(pedido), 0);
    check("estoque_after_refill", int'(estoque), 15);
    repeat (5) tick();

    // First seal with the bottle held: exactly one seal.
    push_a(1'b1, 14, 1);
    garrafa = 1'b1;
    repeat (40) begin
      if (garrafa_ok !== 1'b1) tick();
    end
    check("first_seal_seen", int'(garrafa_ok), 1);
    repeat (10) tick();
    check("held_no_reseal_act", int'(atuador), 0);
    check("held_no_reseal_sel", int'(seladas), 1);
    garrafa = 1'b0;
    tick(); tick();

    // Seal down to the threshold; refill must precede the next seal.
    for (int est = 13; est >= 4; est--) begin
      push_a(1'b1, est, 15 - est);
      if (est == 4) push_a(1'b0, 19, 0);
      run_bottle();
    end
    push_a(1'b1, 18, 12);
    run_bottle();

    // Dispenser empty: drain the buffer, partial buffer still seals.
    vazio = 1'b1;
    for (int est = 17; est >= 0; est--) begin
      push_a(1'b1, est, 30 - est);
      run_bottle();
    end
    check("falta_raised", int'(falta), 1);
    check("falta_no_pedido", int'(pedido), 0);
    garrafa = 1'b1;
    repeat (8) tick();
    check("falta_no_seal_act", int'(atuador), 0);
    check("falta_no_seal_sel", int'(seladas), 30);
    check("falta_held", int'(falta), 1);
    garrafa = 1'b0;
    push_a(1'b0, 15, 0);
    vazio = 1'b0;
    tick();
    check("falta_cleared", int'(falta), 0);
    check("falta_exit_no_pedido", int'(pedido), 0);
    tick();
    check("falta_then_pedido", int'(pedido), 1);
    tick(); tick(); tick();

    // Reset in the 2nd actuator cycle aborts the seal.
    garrafa = 1'b1;
    tick();
    check("abort_act_1st", int'(atuador), 1);
    tick();
    check("abort_act_2nd", int'(atuador), 1);
    reset = 1'b1;
    tick();
    check("abort_atuador", int'(atuador), 0);
    check("abort_estoque", int'(estoque), 0);
    check("abort_seladas", int'(seladas), 0);
    check("abort_ok", int'(garrafa_ok), 0);
    garrafa = 1'b0;
    repeat (4) tick();

    // Instance B: refill to 4, zero-batch refill, then saturation at 16.
    push_b(4);
    push_b(4);
    rst_b = 1'b0;
    tick();
    tick();
    check("b_first_refill", int'(estoque_b), 4);
    disp_b = 8'd0;
    tick();
    check("b_pedido_zero_batch", int'(pedido_b), 1);
    tick();
    vazio_b = 1'b1;
    check("b_zero_batch_est", int'(estoque_b), 4);
    check("b_back_repouso_ped", int'(pedido_b), 0);
    check("b_back_repouso_act", int'(atuador_b), 0);
    check("b_back_repouso_falta", int'(falta_b), 0);
    repeat (3) tick();
    push_b(16);
    disp_b = 8'd15;
    vazio_b = 1'b0;
    tick(); tick();
    repeat (4) tick();
    check("b_saturated", int'(estoque_b), 16);

    repeat (3) tick();
    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_arrolhamento.md
Name: controle_arrolhamento

Overview:
Corking-station controller that sits directly downstream of the cork dispenser. It keeps a local cork buffer and refills it in batches by pulsing the dispenser's ENABLE input and capturing the dispenser's DISPENSADO output. It seals one bottle per arrival by driving the corking actuator for a fixed number of cycles. It reports the local stock, the sealed-bottle count and a cork-shortage alarm to the line supervisor.

Parameters:
CAPACIDADE, 32, maximum corks held in the local buffer; the buffer saturates at this value.
LIMIAR, 4, a refill is requested when the local buffer is <= LIMIAR; LIMIAR+15 <= CAPACIDADE is required.
TEMPO_ARROLHAR, 3, number of cycles ATUADOR stays high per bottle (>= 1).

Ports:
CLOCK  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
GARRAFA_PRESENTE  input  1  bottle positioned under the corker (level signal).
DISPENSADO  input  8  batch size from the dispenser; combinational, meaningful only while PEDIDO=1; values 0..15.
VAZIO_DISP  input  1  dispenser stock is empty.
PEDIDO  output  1  connects to the dispenser ENABLE; high for exactly one cycle per refill.
ATUADOR  output  1  corking actuator drive.
GARRAFA_OK  output  1  one-cycle pulse per sealed bottle.
FALTA_ROLHA  output  1  shortage alarm: local buffer is empty and the dispenser is empty.
ESTOQUE_LOCAL  output  8  local buffer count.
SELADAS  output  16  sealed-bottle counter; wraps 65535 -> 0.

Behaviour:
- Reset: on a clock edge with RESET=1, the block goes to state REPOUSO with ESTOQUE_LOCAL=0, SELADAS=0, PEDIDO=0, ATUADOR=0, GARRAFA_OK=0, FALTA_ROLHA=0, and the internal cycle timer at 0.
  - Reset has priority over every other event and aborts any operation in progress, including mid-ARROLHANDO.
  - An aborted seal neither consumes a cork nor counts as sealed.
- All outputs are registered or decoded from state (Moore). PEDIDO, ATUADOR and FALTA_ROLHA are decoded from state.
- States: REPOUSO, PEDINDO, ARROLHANDO, CONCLUIDO, FALTA.
- REPOUSO: transitions are evaluated in priority order.
  1. ESTOQUE_LOCAL <= LIMIAR and VAZIO_DISP=0 -> PEDINDO.
  2. GARRAFA_PRESENTE=1 and ESTOQUE_LOCAL > 0 -> ARROLHANDO, with the timer loaded to TEMPO_ARROLHAR-1.
  3. ESTOQUE_LOCAL = 0 and VAZIO_DISP=1 -> FALTA.
  4. Otherwise stay in REPOUSO.
  - With a partial buffer (0 < ESTOQUE_LOCAL <= LIMIAR) and VAZIO_DISP=1, bottles are still sealed.
- PEDINDO (exactly one cycle, PEDIDO=1):
  - DISPENSADO is sampled in this same cycle; at the closing edge ESTOQUE_LOCAL <= min(ESTOQUE_LOCAL + DISPENSADO, CAPACIDADE).
  - Internal sum is 9 bits wide, no overflow.
  - DISPENSADO=0 (dispenser emptied concurrently) leaves the buffer unchanged.
  - Always returns to REPOUSO.
- ARROLHANDO (ATUADOR=1): lasts exactly TEMPO_ARROLHAR cycles; the timer decrements each cycle.
  - At the edge where the timer is 0: ESTOQUE_LOCAL decrements by 1, SELADAS increments by 1, GARRAFA_OK=1 for the following single cycle, and the state goes to CONCLUIDO.
  - Removing the bottle mid-seal does not abort the seal.
- CONCLUIDO: wait for GARRAFA_PRESENTE=0, then go to REPOUSO.
  - This prevents one bottle from being sealed twice.
  - No refill is requested while in CONCLUIDO.
- FALTA (FALTA_ROLHA=1): on VAZIO_DISP=0 go to REPOUSO; the next cycle then enters PEDINDO.
- ESTOQUE_LOCAL never underflows: sealing requires ESTOQUE_LOCAL > 0.
- ESTOQUE_LOCAL never exceeds CAPACIDADE.
- Latencies:
  - Refill: 2 edges from a REPOUSO condition to the updated ESTOQUE_LOCAL.
  - Seal: TEMPO_ARROLHAR + 1 edges from entering ARROLHANDO to SELADAS updated.

Test Plan:
- Reset, VAZIO_DISP=0, DISPENSADO=15 -> PEDIDO high for one cycle, in the 2nd cycle after reset release; ESTOQUE_LOCAL=15; then PEDIDO stays 0 while ESTOQUE_LOCAL > 4.
- ESTOQUE_LOCAL=15, GARRAFA_PRESENTE=1 held -> ATUADOR high for exactly 3 cycles; ESTOQUE_LOCAL=14, SELADAS=1; one GARRAFA_OK pulse; no second seal until GARRAFA_PRESENTE falls and rises again.
- Seal repeatedly down to ESTOQUE_LOCAL=4 -> PEDIDO pulses before the next seal; DISPENSADO=15 -> ESTOQUE_LOCAL=19.
- VAZIO_DISP=1, ESTOQUE_LOCAL=2, 2 bottles sealed -> ESTOQUE_LOCAL=0, FALTA_ROLHA=1, PEDIDO stays 0; a new bottle is not sealed. Drop VAZIO_DISP -> FALTA_ROLHA=0, then a PEDIDO pulse.
- ESTOQUE_LOCAL=4 with a forced DISPENSADO=15 and CAPACIDADE=16 -> ESTOQUE_LOCAL saturates at 16. With DISPENSADO=0 during PEDIDO -> ESTOQUE_LOCAL unchanged and the state returns to REPOUSO.
- RESET asserted in the 2nd ATUADOR cycle -> after the next edge ATUADOR=0, ESTOQUE_LOCAL=0, SELADAS=0, and no GARRAFA_OK pulse.
